// File: rtl/turtle_loader_pkg.sv
// -----------------------------------------------------------------------------
// turtle_loader_pkg
// Shared types and constants for the Turtle CPU instruction-memory UART loader.
//   loader_state_t   : loader sequencing states
//   LOADER_SYNC_BYTE : byte that opens an image frame
//   LOADER_LEN_WIDTH : width of the big-endian word-count field
//   checksum_update  : running XOR used by the optional image checksum
//                      (TURTLE_LOADER_CHECKSUM_EN)
// -----------------------------------------------------------------------------
package turtle_loader_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_H  = 3'd1,
    LEN_L  = 3'd2,
    DATA_H = 3'd3,
    DATA_L = 3'd4,
    CHECK  = 3'd5,
    DONE   = 3'd6
  } loader_state_t;

  localparam logic [7:0] LOADER_SYNC_BYTE = 8'hA5;
  localparam int         LOADER_LEN_WIDTH = 16;

  // Fold one payload byte into the running image checksum.
  function automatic logic [7:0] checksum_update(input logic [7:0] csum,
                                                 input logic [7:0] data);
    return csum ^ data;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// -----------------------------------------------------------------------------
// uart_rx_byte
// 8N1 UART byte receiver with a 2-flop input synchroniser.
// A falling edge while idle starts a frame; the start bit is re-checked half a
// bit later so short low glitches are dropped. Data is sampled LSB-first at
// full-bit intervals, then the stop bit.
// Ports:
//   clk        in   system clock
//   reset_n    in   asynchronous active-low reset
//   uart_rx    in   asynchronous serial line, idle high
//   byte_valid out  1-cycle pulse, one cycle after a good stop-bit sample
//   byte_data  out  received byte, valid with byte_valid (holds afterwards)
//   frame_err  out  1-cycle pulse when the stop bit samples low
// -----------------------------------------------------------------------------
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       uart_rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  logic             rx_meta_r;
  logic             rx_sync_r;
  logic             rx_prev_r;
  rx_state_t        state_r, state_next;
  logic [CNT_W-1:0] cnt_r, cnt_next;
  logic [2:0]       bit_idx_r, bit_idx_next;
  logic [7:0]       shift_r, shift_next;
  logic             byte_valid_r, byte_valid_next;
  logic [7:0]       byte_data_r, byte_data_next;
  logic             frame_err_r, frame_err_next;

  // Synchroniser, edge-detect history and receiver state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_r    <= 1'b1;
      rx_sync_r    <= 1'b1;
      rx_prev_r    <= 1'b1;
      state_r      <= RX_IDLE;
      cnt_r        <= {CNT_W{1'b0}};
      bit_idx_r    <= 3'd0;
      shift_r      <= 8'h00;
      byte_valid_r <= 1'b0;
      byte_data_r  <= 8'h00;
      frame_err_r  <= 1'b0;
    end else begin
      rx_meta_r    <= uart_rx;
      rx_sync_r    <= rx_meta_r;
      rx_prev_r    <= rx_sync_r;
      state_r      <= state_next;
      cnt_r        <= cnt_next;
      bit_idx_r    <= bit_idx_next;
      shift_r      <= shift_next;
      byte_valid_r <= byte_valid_next;
      byte_data_r  <= byte_data_next;
      frame_err_r  <= frame_err_next;
    end
  end

  // Bit timing and framing: next state, sample points and result pulses.
  always_comb begin
    state_next      = state_r;
    cnt_next        = cnt_r;
    bit_idx_next    = bit_idx_r;
    shift_next      = shift_r;
    byte_valid_next = 1'b0;
    byte_data_next  = byte_data_r;
    frame_err_next  = 1'b0;
    case (state_r)
      RX_IDLE: begin
        cnt_next     = {CNT_W{1'b0}};
        bit_idx_next = 3'd0;
        if (rx_prev_r && !rx_sync_r) begin
          state_next = RX_START;
        end else begin
          state_next = RX_IDLE;
        end
      end
      RX_START: begin
        if (cnt_r == HALF_M1) begin
          cnt_next = {CNT_W{1'b0}};
          // A start bit that is high again at mid-bit was only a glitch.
          if (!rx_sync_r) begin
            state_next = RX_DATA;
          end else begin
            state_next = RX_IDLE;
          end
        end else begin
          cnt_next = cnt_r + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (cnt_r == FULL_M1) begin
          cnt_next   = {CNT_W{1'b0}};
          shift_next = {rx_sync_r, shift_r[7:1]};
          if (bit_idx_r == 3'd7) begin
            bit_idx_next = 3'd0;
            state_next   = RX_STOP;
          end else begin
            bit_idx_next = bit_idx_r + 3'd1;
          end
        end else begin
          cnt_next = cnt_r + CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (cnt_r == FULL_M1) begin
          cnt_next   = {CNT_W{1'b0}};
          state_next = RX_IDLE;
          if (rx_sync_r) begin
            byte_valid_next = 1'b1;
            byte_data_next  = shift_r;
          end else begin
            frame_err_next = 1'b1;
          end
        end else begin
          cnt_next = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_next = RX_IDLE;
      end
    endcase
  end

  assign byte_valid = byte_valid_r;
  assign byte_data  = byte_data_r;
  assign frame_err  = frame_err_r;

endmodule

// File: rtl/imem_uart_loader.sv
// -----------------------------------------------------------------------------
// imem_uart_loader
// Receives a framed program image over UART and writes 16-bit words into the
// Turtle CPU instruction memory from address 0, holding the CPU in reset while
// loading. Frame: A5, LEN_HI, LEN_LO, then LEN words (high byte first).
// Optional build macro TURTLE_LOADER_CHECKSUM_EN adds a trailing byte that
// must equal the XOR of all payload bytes.
// Ports:
//   clk         in   system clock
//   reset_n     in   asynchronous active-low reset
//   uart_rx     in   serial input, idle high, 8N1
//   imem_we     out  one-cycle write strobe per word
//   imem_addr   out  write address (holds after the write)
//   imem_wdata  out  instruction word (holds after the write)
//   cpu_hold    out  high keeps the CPU in reset
//   load_done   out  one-cycle pulse on successful completion
//   load_error  out  sticky error, cleared by the next SYNC byte
// -----------------------------------------------------------------------------
module imem_uart_loader #(
  parameter int CLK_FREQ_HZ     = 100_000_000,
  parameter int BAUD_RATE       = 115_200,
  parameter int IMEM_ADDR_WIDTH = 10
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       uart_rx,
  output logic                       imem_we,
  output logic [IMEM_ADDR_WIDTH-1:0] imem_addr,
  output logic [15:0]                imem_wdata,
  output logic                       cpu_hold,
  output logic                       load_done,
  output logic                       load_error
);

  import turtle_loader_pkg::*;

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
  localparam int CNT_W        = IMEM_ADDR_WIDTH + 1;
  localparam int CMP_W        = LOADER_LEN_WIDTH + 1;
  localparam logic [CMP_W-1:0] DEPTH = CMP_W'(2 ** IMEM_ADDR_WIDTH);

  logic       byte_valid_s;
  logic [7:0] byte_data_s;
  logic       frame_err_s;

  loader_state_t               state_r, state_next;
  logic [LOADER_LEN_WIDTH-1:0] len_r, len_next;
  logic [7:0]                  hi_r, hi_next;
  logic [CNT_W-1:0]            word_cnt_r, word_cnt_next;
  logic                        imem_we_r, imem_we_next;
  logic [IMEM_ADDR_WIDTH-1:0]  imem_addr_r, imem_addr_next;
  logic [15:0]                 imem_wdata_r, imem_wdata_next;
  logic                        cpu_hold_r, cpu_hold_next;
  logic                        load_done_r, load_done_next;
  logic                        load_error_r, load_error_next;
`ifdef TURTLE_LOADER_CHECKSUM_EN
  logic [7:0]                  csum_r, csum_next;
`endif

  logic [LOADER_LEN_WIDTH-1:0] len_full_s;
  logic [CMP_W-1:0]            words_done_s;
  logic                        last_word_s;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk       (clk),
    .reset_n   (reset_n),
    .uart_rx   (uart_rx),
    .byte_valid(byte_valid_s),
    .byte_data (byte_data_s),
    .frame_err (frame_err_s)
  );

  assign len_full_s   = {len_r[15:8], byte_data_s};
  // Count including the word being written now; compared at full length width.
  assign words_done_s = CMP_W'(word_cnt_r) + CMP_W'(1);
  assign last_word_s  = (words_done_s == {1'b0, len_r});

  // Loader state and registered memory/status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= IDLE;
      len_r        <= 16'h0000;
      hi_r         <= 8'h00;
      word_cnt_r   <= {CNT_W{1'b0}};
      imem_we_r    <= 1'b0;
      imem_addr_r  <= {IMEM_ADDR_WIDTH{1'b0}};
      imem_wdata_r <= 16'h0000;
      cpu_hold_r   <= 1'b0;
      load_done_r  <= 1'b0;
      load_error_r <= 1'b0;
`ifdef TURTLE_LOADER_CHECKSUM_EN
      csum_r       <= 8'h00;
`endif
    end else begin
      state_r      <= state_next;
      len_r        <= len_next;
      hi_r         <= hi_next;
      word_cnt_r   <= word_cnt_next;
      imem_we_r    <= imem_we_next;
      imem_addr_r  <= imem_addr_next;
      imem_wdata_r <= imem_wdata_next;
      cpu_hold_r   <= cpu_hold_next;
      load_done_r  <= load_done_next;
      load_error_r <= load_error_next;
`ifdef TURTLE_LOADER_CHECKSUM_EN
      csum_r       <= csum_next;
`endif
    end
  end

  // Frame parsing: next state plus next values of every loader register.
  always_comb begin
    state_next      = state_r;
    len_next        = len_r;
    hi_next         = hi_r;
    word_cnt_next   = word_cnt_r;
    imem_we_next    = 1'b0;
    imem_addr_next  = imem_addr_r;
    imem_wdata_next = imem_wdata_r;
    cpu_hold_next   = cpu_hold_r;
    load_done_next  = 1'b0;
    load_error_next = load_error_r;
`ifdef TURTLE_LOADER_CHECKSUM_EN
    csum_next       = csum_r;
`endif
    case (state_r)
      IDLE: begin
        if (byte_valid_s && (byte_data_s == LOADER_SYNC_BYTE)) begin
          cpu_hold_next   = 1'b1;
          load_error_next = 1'b0;
          word_cnt_next   = {CNT_W{1'b0}};
          len_next        = 16'h0000;
`ifdef TURTLE_LOADER_CHECKSUM_EN
          csum_next       = 8'h00;
`endif
          state_next      = LEN_H;
        end else begin
          state_next = IDLE;
        end
      end
      LEN_H: begin
        if (frame_err_s) begin
          load_error_next = 1'b1;
          state_next      = IDLE;
        end else if (byte_valid_s) begin
          len_next   = {byte_data_s, 8'h00};
          state_next = LEN_L;
        end else begin
          state_next = LEN_H;
        end
      end
      LEN_L: begin
        if (frame_err_s) begin
          load_error_next = 1'b1;
          state_next      = IDLE;
        end else if (byte_valid_s) begin
          len_next = len_full_s;
          if (len_full_s == 16'h0000) begin
            load_done_next = 1'b1;
            cpu_hold_next  = 1'b0;
            state_next     = IDLE;
          end else if ({1'b0, len_full_s} > DEPTH) begin
            // Oversized image: refuse it and keep the CPU held.
            load_error_next = 1'b1;
            state_next      = IDLE;
          end else begin
            state_next = DATA_H;
          end
        end else begin
          state_next = LEN_L;
        end
      end
      DATA_H: begin
        if (frame_err_s) begin
          load_error_next = 1'b1;
          state_next      = IDLE;
        end else if (byte_valid_s) begin
          hi_next    = byte_data_s;
`ifdef TURTLE_LOADER_CHECKSUM_EN
          csum_next  = checksum_update(csum_r, byte_data_s);
`endif
          state_next = DATA_L;
        end else begin
          state_next = DATA_H;
        end
      end
      DATA_L: begin
        if (frame_err_s) begin
          load_error_next = 1'b1;
          state_next      = IDLE;
        end else if (byte_valid_s) begin
          imem_we_next    = 1'b1;
          imem_addr_next  = word_cnt_r[IMEM_ADDR_WIDTH-1:0];
          imem_wdata_next = {hi_r, byte_data_s};
          word_cnt_next   = word_cnt_r + {{IMEM_ADDR_WIDTH{1'b0}}, 1'b1};
`ifdef TURTLE_LOADER_CHECKSUM_EN
          csum_next       = checksum_update(csum_r, byte_data_s);
`endif
          if (last_word_s) begin
`ifdef TURTLE_LOADER_CHECKSUM_EN
            state_next = CHECK;
`else
            state_next = DONE;
`endif
          end else begin
            state_next = DATA_H;
          end
        end else begin
          state_next = DATA_L;
        end
      end
      CHECK: begin
`ifdef TURTLE_LOADER_CHECKSUM_EN
        if (frame_err_s) begin
          load_error_next = 1'b1;
          state_next      = IDLE;
        end else if (byte_valid_s) begin
          if (byte_data_s == csum_r) begin
            state_next = DONE;
          end else begin
            load_error_next = 1'b1;
            state_next      = IDLE;
          end
        end else begin
          state_next = CHECK;
        end
`else
        state_next = IDLE;
`endif
      end
      DONE: begin
        load_done_next = 1'b1;
        cpu_hold_next  = 1'b0;
        state_next     = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign imem_we    = imem_we_r;
  assign imem_addr  = imem_addr_r;
  assign imem_wdata = imem_wdata_r;
  assign cpu_hold   = cpu_hold_r;
  assign load_done  = load_done_r;
  assign load_error = load_error_r;

endmodule

// File: tb/tb_imem_uart_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_uart_loader
// Self-checking bench for imem_uart_loader. Frames are built as byte lists and
// their outcome (writes, done pulses, final hold/error) is predicted from the
// frame contents; a per-cycle monitor compares the DUT against those
// predictions. Honours TURTLE_LOADER_CHECKSUM_EN like the design.
// -----------------------------------------------------------------------------
module tb_imem_uart_loader;

  localparam int CLK_HZ = 100_000_000;
  localparam int BAUD   = 5_000_000;
  localparam int CPB    = CLK_HZ / BAUD;
  localparam int AW     = 4;
  localparam int DEPTH  = 16;
`ifdef TURTLE_LOADER_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          uart_rx = 1'b1;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [15:0]   imem_wdata;
  logic          cpu_hold;
  logic          load_done;
  logic          load_error;

  imem_uart_loader #(
    .CLK_FREQ_HZ    (CLK_HZ),
    .BAUD_RATE      (BAUD),
    .IMEM_ADDR_WIDTH(AW)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .uart_rx   (uart_rx),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .load_error(load_error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] exp_addr_q[$];
  logic [15:0]   exp_data_q[$];
  bit            exp_done_q[$];
  logic [AW-1:0] act_addr_log[$];
  logic [15:0]   act_data_log[$];
  logic [15:0]   frame_words[$];
  logic [8:0]    junk_q[$];
  logic          exp_hold = 1'b0;
  logic          exp_err = 1'b0;
  logic [7:0]    last_csum_byte;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Per-cycle monitor: writes, held address/data, and done pulses.
  initial begin
    logic [AW-1:0] last_addr;
    logic [15:0]   last_data;
    longint        cyc;
    longint        last_we_cyc;
    logic          prev_hold;
    bit            follows_we;
    last_addr = '0; last_data = 16'h0000; cyc = 0; last_we_cyc = -10; prev_hold = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset_n) begin
        last_addr = '0; last_data = 16'h0000; prev_hold = 1'b0;
      end else begin
        if (imem_we) begin
          act_addr_log.push_back(imem_addr);
          act_data_log.push_back(imem_wdata);
          if (exp_addr_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_write actual=0x%0h@0x%0h expected=none", imem_wdata, imem_addr);
          end else begin
            last_addr = exp_addr_q.pop_front();
            last_data = exp_data_q.pop_front();
            chk("write_addr", imem_addr, last_addr);
            chk("write_data", imem_wdata, last_data);
          end
          last_we_cyc = cyc;
        end else begin
          chk("addr_hold", imem_addr, last_addr);
          chk("wdata_hold", imem_wdata, last_data);
        end
        if (load_done) begin
          if (exp_done_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_done actual=1 expected=0");
          end else begin
            follows_we = exp_done_q.pop_front();
            chk("hold_at_done", cpu_hold, 0);
            chk("hold_before_done", prev_hold, 1);
            if (follows_we) chk("done_after_we", 32'(cyc - last_we_cyc), 1);
          end
        end
        prev_hold = cpu_hold;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    uart_rx = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(posedge clk);
    end
    uart_rx = stop_bit;
    repeat (CPB) @(posedge clk);
    uart_rx = 1'b1;
    repeat (3 + $urandom_range(0, 8)) @(posedge clk);
  endtask

  // Sends junk_q, then A5/len/payload(/checksum); fe_k>0 drives that byte's stop low.
  task automatic run_frame(input int n, input int fe_k, input bit bad_csum);
    logic [7:0]  q[$];
    logic [15:0] n16;
    logic [7:0]  cs;
    logic [8:0]  j;
    n16 = 16'(n);
    cs  = 8'h00;
    q.push_back(8'hA5); q.push_back(n16[15:8]); q.push_back(n16[7:0]);
    if (n <= DEPTH) begin
      for (int i = 0; i < n; i++) begin
        q.push_back(frame_words[i][15:8]);
        q.push_back(frame_words[i][7:0]);
        cs = cs ^ frame_words[i][15:8] ^ frame_words[i][7:0];
      end
    end
    last_csum_byte = bad_csum ? (cs ^ 8'h01) : cs;
    if (CSUM && n > 0 && n <= DEPTH) q.push_back(last_csum_byte);

    while (junk_q.size() > 0) begin
      j = junk_q.pop_front();
      send_byte(j[7:0], j[8]);
    end
    chk("idle_hold", cpu_hold, exp_hold);
    chk("idle_err", load_error, exp_err);

    if (fe_k > 0) begin
      for (int i = 0; i < n && n <= DEPTH; i++) begin
        if (4 + 2 * i < fe_k) begin
          exp_addr_q.push_back(AW'(i)); exp_data_q.push_back(frame_words[i]);
        end
      end
      exp_hold = 1'b1; exp_err = 1'b1;
    end else if (n == 0) begin
      exp_done_q.push_back(1'b0); exp_hold = 1'b0; exp_err = 1'b0;
    end else if (n > DEPTH) begin
      exp_hold = 1'b1; exp_err = 1'b1;
    end else begin
      for (int i = 0; i < n; i++) begin
        exp_addr_q.push_back(AW'(i)); exp_data_q.push_back(frame_words[i]);
      end
      if (CSUM && bad_csum) begin
        exp_hold = 1'b1; exp_err = 1'b1;
      end else begin
        exp_done_q.push_back(1'b1); exp_hold = 1'b0; exp_err = 1'b0;
      end
    end

    send_byte(q[0], 1'b1);
    chk("hold_after_sync", cpu_hold, 1);
    chk("err_after_sync", load_error, 0);
    for (int k = 1; k < q.size(); k++) begin
      if (k == fe_k) begin
        send_byte(q[k], 1'b0);
        break;
      end else begin
        send_byte(q[k], 1'b1);
      end
    end
    repeat (10) @(posedge clk);
    chk("writes_pending", exp_addr_q.size(), 0);
    chk("done_pending", exp_done_q.size(), 0);
    chk("end_hold", cpu_hold, exp_hold);
    chk("end_err", load_error, exp_err);
  endtask

  initial begin
    int n, flen, fe_k;
    logic [7:0] jb;
    // Reset values
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("rst_we", imem_we, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_wdata", imem_wdata, 0);
    chk("rst_hold", cpu_hold, 0);
    chk("rst_done", load_done, 0);
    chk("rst_err", load_error, 0);
    reset_n = 1'b1;
    repeat (5) @(posedge clk);

    // Three-word image
    act_addr_log.delete(); act_data_log.delete();
    frame_words = {16'h1234, 16'hABCD, 16'h0001};
    run_frame(3, -1, 1'b0);
    chk("t1_nwrites", act_data_log.size(), 3);
    chk("t1_w0", act_data_log[0], 16'h1234);
    chk("t1_w1", act_data_log[1], 16'hABCD);
    chk("t1_w2", act_data_log[2], 16'h0001);
    chk("t1_a2", act_addr_log[2], 2);
    chk("t1_hold", cpu_hold, 0);

    // Leading junk then empty image
    act_data_log.delete();
    junk_q = {9'h100, 9'h1FF};
    run_frame(0, -1, 1'b0);
    chk("t2_nwrites", act_data_log.size(), 0);
    chk("t2_hold", cpu_hold, 0);

    // Oversized image, then a valid one clears the error
    run_frame(17, -1, 1'b0);
    chk("t3_err", load_error, 1);
    chk("t3_hold", cpu_hold, 1);
    chk("t3_nwrites", act_data_log.size(), 0);
    frame_words = {16'h5A5A};
    run_frame(1, -1, 1'b0);
    chk("t3_err_clr", load_error, 0);
    chk("t3_w0", act_data_log[0], 16'h5A5A);
    chk("t3_a0", act_addr_log[0], 0);

    // Framing error on the low byte of the first word
    act_data_log.delete();
    frame_words = {16'h1122, 16'h3344};
    run_frame(2, 4, 1'b0);
    chk("t4_nwrites", act_data_log.size(), 0);
    chk("t4_err", load_error, 1);
    chk("t4_hold", cpu_hold, 1);

    // Start-bit glitch while idle
    uart_rx = 1'b0;
    repeat (CPB / 2 - 4) @(posedge clk);
    uart_rx = 1'b1;
    repeat (4 * CPB) @(posedge clk);
    chk("glitch_err", load_error, 1);
    chk("glitch_hold", cpu_hold, 1);
    chk("glitch_nwrites", act_data_log.size(), 0);

`ifdef TURTLE_LOADER_CHECKSUM_EN
    frame_words = {16'h1234};
    run_frame(1, -1, 1'b0);
    chk("csum_good_byte", last_csum_byte, 8'h26);
    chk("csum_good_err", load_error, 0);
    run_frame(1, -1, 1'b1);
    chk("csum_bad_byte", last_csum_byte, 8'h27);
    chk("csum_bad_err", load_error, 1);
    chk("csum_bad_hold", cpu_hold, 1);
`endif

    // Full-depth image: addresses 0..15, no wrap
    frame_words.delete();
    for (int i = 0; i < DEPTH; i++) frame_words.push_back(16'($urandom));
    run_frame(DEPTH, -1, 1'b0);

    // Reset in the middle of a load
    frame_words = {16'hBEEF, 16'hCAFE, 16'hF00D};
    exp_addr_q.push_back(AW'(0)); exp_data_q.push_back(16'hBEEF);
    send_byte(8'hA5, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h03, 1'b1);
    send_byte(8'hBE, 1'b1); send_byte(8'hEF, 1'b1); send_byte(8'hCA, 1'b1);
    chk("mid_hold", cpu_hold, 1);
    chk("mid_writes_pending", exp_addr_q.size(), 0);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_we", imem_we, 0);
    chk("mid_rst_addr", imem_addr, 0);
    chk("mid_rst_wdata", imem_wdata, 0);
    chk("mid_rst_hold", cpu_hold, 0);
    chk("mid_rst_err", load_error, 0);
    exp_hold = 1'b0; exp_err = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(posedge clk);

    // Randomised frames
    for (int f = 0; f < 10; f++) begin
      case ($urandom_range(0, 9))
        0: n = 0;
        1: n = DEPTH + 1 + int'($urandom_range(0, 3));
        2: n = DEPTH;
        default: n = int'($urandom_range(1, 5));
      endcase
      frame_words.delete();
      for (int i = 0; i < n && i < DEPTH; i++) begin
        if ($urandom_range(0, 3) == 0) frame_words.push_back({8'hA5, 8'($urandom)});
        else frame_words.push_back(16'($urandom));
      end
      flen = 3 + ((n <= DEPTH) ? 2 * n : 0) + ((CSUM && n > 0 && n <= DEPTH) ? 1 : 0);
      fe_k = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, flen - 1)) : -1;
      for (int i = 0; i < int'($urandom_range(0, 2)); i++) begin
        jb = 8'($urandom);
        if (jb == 8'hA5) jb = 8'h5A;
        junk_q.push_back({1'($urandom_range(0, 1)), jb});
      end
      run_frame(n, fe_k, 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
